// File: rtl/cmp_operand_loader.sv
// cmp_operand_loader: assembles two OP_W-bit operands from a WORD_W-bit
// valid/ready word stream (least-significant word first), holds them stable
// on cmp_a/cmp_b for the external less-than comparator, captures its result
// and offers it to the consumer on a valid/ready handshake.
module cmp_operand_loader #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [OP_W-1:0]   cmp_a,
  output logic [OP_W-1:0]   cmp_b,
  input  logic              cmp_lt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_lt
);

  localparam int NWORDS = OP_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OP_W-1:0]   cmp_a_q, cmp_a_d;
  logic [OP_W-1:0]   cmp_b_q, cmp_b_d;
  logic              res_valid_q, res_valid_d;
  logic              res_lt_q, res_lt_d;
  logic              in_ready_s;
  logic              word_accept_s;

  // State register: all flops, asynchronously cleared by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_lt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      res_valid_q <= res_valid_d;
      res_lt_q    <= res_lt_d;
    end
  end

  // Next-state and datapath: word placement, compare capture, result handshake; flush wins.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    res_valid_d = res_valid_q;
    res_lt_d    = res_lt_q;
    if (flush) begin
      // Abort: a word offered this cycle is dropped and any pending result discarded.
      state_d     = LOAD_A;
      idx_d       = '0;
      cmp_a_d     = '0;
      cmp_b_d     = '0;
      res_valid_d = 1'b0;
      res_lt_d    = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (word_accept_s) begin
            cmp_a_d[idx_q*WORD_W +: WORD_W] = in_data;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = LOAD_B;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        LOAD_B: begin
          if (word_accept_s) begin
            cmp_b_d[idx_q*WORD_W +: WORD_W] = in_data;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = COMPARE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        COMPARE: begin
          // Operands have been stable for a full cycle; capture the comparator.
          res_lt_d    = cmp_lt;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
        RESULT: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            state_d     = LOAD_A;
          end else begin
            state_d = RESULT;
          end
        end
        default: begin
          state_d     = LOAD_A;
          idx_d       = '0;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output decode: in_ready follows the loading states; everything else is a flop.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      LOAD_A:  in_ready_s = 1'b1;
      LOAD_B:  in_ready_s = 1'b1;
      COMPARE: in_ready_s = 1'b0;
      RESULT:  in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
    word_accept_s = in_valid && in_ready_s;
    in_ready      = in_ready_s;
    cmp_a         = cmp_a_q;
    cmp_b         = cmp_b_q;
    res_valid     = res_valid_q;
    res_lt        = res_lt_q;
  end

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Scoreboard bench for cmp_operand_loader: stimulus pushes hand-computed
// expected results; a monitor pops and compares on every result handshake.
module tb_cmp_operand_loader;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [127:0] cmp_a;
  logic [127:0] cmp_b;
  logic         cmp_lt;
  logic         res_valid;
  logic         res_ready;
  logic         res_lt;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_cnt  = 0;
  logic sb[$];

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MSB  = {1'b1, 127'd0};
  localparam logic [127:0] LOW  = {1'b0, {127{1'b1}}};

  cmp_operand_loader #(.WORD_W(32), .OP_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt),
    .res_valid(res_valid), .res_ready(res_ready), .res_lt(res_lt)
  );

  // Combinational unsigned comparator the loader feeds.
  assign cmp_lt = (cmp_a < cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, when stimulus has settled.
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !flush && in_valid && in_ready) acc_cnt++;
      if (rst_n && res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got res_lt=%0b with empty scoreboard", res_lt);
        end else begin
          e = sb.pop_front();
          if (res_lt !== e) begin
            n_fail++;
            $display("FAIL res_lt: got %0b expected %0b", res_lt, e);
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the word is accepted.
  task automatic send_word(input logic [31:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [127:0] v, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_word(v[k*32 +: 32]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic run_pair(input logic [127:0] a, input logic [127:0] b, input logic exp);
    load_op(a, 1'b0);
    load_op(b, 1'b0);
    sb.push_back(exp);
  endtask

  task automatic wait_result();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [31:0]  c0;
    logic [127:0] a0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_res_valid", 128'(res_valid), 128'd0);
    check("reset_res_lt", 128'(res_lt), 128'd0);
    check("reset_cmp_a", cmp_a, 128'd0);
    check("reset_cmp_b", cmp_b, 128'd0);

    // Basic load, latency and handshake.
    load_op(128'd1, 1'b0);
    load_op(128'd2, 1'b0);
    check("basic_cmp_a", cmp_a, 128'd1);
    check("basic_cmp_b", cmp_b, 128'd2);
    check("lat_compare_valid", 128'(res_valid), 128'd0);
    sb.push_back(1'b1);
    @(negedge clk);
    check("lat_result_valid", 128'(res_valid), 128'd1);
    check("lat_result_lt", 128'(res_lt), 128'd1);
    check("result_in_ready", 128'(in_ready), 128'd0);
    res_ready = 1'b1;
    @(negedge clk);
    check("back_to_load_ready", 128'(in_ready), 128'd1);
    check("back_to_load_valid", 128'(res_valid), 128'd0);
    check("keep_cmp_a", cmp_a, 128'd1);

    // Boundary operands.
    run_pair(ONES, ONES, 1'b0);
    wait_result();
    run_pair(MSB, LOW, 1'b0);
    wait_result();
    run_pair(LOW, MSB, 1'b1);
    wait_result();

    // in_valid toggling every other cycle.
    c0 = acc_cnt;
    load_op(128'h9_0000_0000_0000_0000_0000_0009, 1'b1);
    load_op(128'hA_0000_0000_0000_0000_0000_0000, 1'b1);
    sb.push_back(1'b1);
    check("gap_accept_count", 128'(acc_cnt - c0), 128'd8);
    check("gap_cmp_a", cmp_a, 128'h9_0000_0000_0000_0000_0000_0009);
    wait_result();

    // Consumer stall in RESULT with extra words offered.
    res_ready = 1'b0;
    run_pair(128'h1_0000_0000, 128'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    c0 = acc_cnt;
    a0 = cmp_a;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("stall_res_valid", 128'(res_valid), 128'd1);
      check("stall_res_lt", 128'(res_lt), 128'd0);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_no_accept", 128'(acc_cnt - c0), 128'd0);
    check("stall_cmp_a", cmp_a, 128'h1_0000_0000);
    check("stall_cmp_a_held", cmp_a, a0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("pulse_valid_drop", 128'(res_valid), 128'd0);
    check("pulse_in_ready", 128'(in_ready), 128'd1);
    res_ready = 1'b1;

    // flush after two B words, with a word presented in the flush cycle.
    load_op(128'd7, 1'b0);
    send_word(32'h11);
    send_word(32'h22);
    c0 = acc_cnt;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_cmp_a", cmp_a, 128'd0);
    check("flush_cmp_b", cmp_b, 128'd0);
    check("flush_idx", 128'(dut.idx_q), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    check("flush_res_valid", 128'(res_valid), 128'd0);
    check("flush_no_accept", 128'(acc_cnt - c0), 128'd0);
    run_pair(128'd5, 128'd3, 1'b0);
    check("post_flush_cmp_a", cmp_a, 128'd5);
    check("post_flush_cmp_b", cmp_b, 128'd3);
    wait_result();

    // Asynchronous reset while a result is held.
    res_ready = 1'b0;
    load_op(128'd0, 1'b0);
    load_op(128'd5, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", 128'(res_valid), 128'd1);
    check("pre_reset_lt", 128'(res_lt), 128'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_res_valid", 128'(res_valid), 128'd0);
    check("async_res_lt", 128'(res_lt), 128'd0);
    check("async_in_ready", 128'(in_ready), 128'd1);
    check("async_cmp_b", cmp_b, 128'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    run_pair(128'd0, 128'd1, 1'b1);
    wait_result();

    check("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
